// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter.
// The CPU side pushes bytes into a small circular FIFO. A baud-rate FSM
// pops them and shifts them out LSB-first, so single-cycle stores are
// decoupled from frames that last 10*CLKS_PER_BIT cycles.
module uart_tx #(
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int UART_BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CLKS_PER_BIT = SYS_CLK_FREQ / UART_BAUD_RATE;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DEPTH        = 1 << FIFO_DEPTH_LOG2;
  localparam int PW           = FIFO_DEPTH_LOG2;

  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          baud_end;
  logic          pop;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic          push;

  // ---------------------------------------------------------------- FIFO
  assign push = wr_en && !full;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; full/empty are registered alongside the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == COUNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // ----------------------------------------------------------------- FSM
  assign baud_end = (baud_cnt == BAUD_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; STOP chains straight into START when bytes are waiting.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!empty) state_nxt = START;
      START: if (baud_end) state_nxt = DATA;
      DATA:  if (baud_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (baud_end) state_nxt = empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded outputs and the FIFO pop strobe, all from registered state.
  always_comb begin
    pop     = ((state == IDLE) || (state == STOP && baud_end)) && !empty;
    busy    = (state != IDLE);
    tx_done = (state == STOP) && baud_end;
  end

  // Baud counter, bit index, shift register and the registered line driver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      baud_cnt <= (state == IDLE || baud_end) ? '0 : baud_cnt + 1'b1;
      if (pop) begin
        shreg <= mem[rd_ptr];
        tx    <= 1'b0;
      end else begin
        case (state)
          START: if (baud_end) begin
            tx      <= shreg[0];
            bit_idx <= '0;
          end
          DATA: if (baud_end) begin
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
          default: tx <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with 16 clocks per bit and an
// 8-entry FIFO. Inputs are driven and outputs sampled on the falling edge.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, tx_done, tx;

  int errors = 0;
  int checks = 0;

  uart_tx #(.SYS_CLK_FREQ(16), .UART_BAUD_RATE(1), .FIFO_DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy), .tx_done(tx_done), .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Follows one frame on the line. c0 = 0: wait (bounded) for the start bit
  // and report the number of falling edges waited in gap. c0 > 0: the caller
  // is already at that cycle of the frame (cycle 1 = first cycle tx is low).
  // Returns at the falling edge of cycle 160.
  task automatic rx_frame(input int c0, output logic [7:0] b, output int gap,
                          output bit shape_ok, output bit done_ok);
    int c, k, o;
    gap = 0; b = 8'h00; shape_ok = 1'b1; done_ok = 1'b1;
    if (c0 == 0) begin
      while (tx !== 1'b0 && gap < 400) begin
        @(negedge clk);
        gap++;
      end
      c = 1;
    end else begin
      c = c0;
    end
    if (tx !== 1'b0 && c <= 16) begin
      shape_ok = 1'b0; done_ok = 1'b0;
      return;
    end
    while (c <= 160) begin
      if (c <= 16) begin
        if (tx !== 1'b0) shape_ok = 1'b0;
      end else if (c <= 144) begin
        k = (c - 17) / 16;
        o = (c - 17) % 16;
        if (o == 0) b[k] = tx;
        else if (tx !== b[k]) shape_ok = 1'b0;
      end else begin
        if (tx !== 1'b1) shape_ok = 1'b0;
      end
      if (tx_done !== (c == 160)) done_ok = 1'b0;
      if (c < 160) @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'h33;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
    wr_en = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (empty !== 1'b1 || tx !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL reset_release: empty=%b tx=%b busy=%b want 1 1 0", empty, tx, busy); end
  endtask

  task automatic test_single();
    logic [7:0] b; int gap; bit sok, dok;
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (tx !== 1'b1 || empty !== 1'b0)
      begin errors++; $display("FAIL single_after_push: tx=%b empty=%b want 1 0", tx, empty); end
    rx_frame(0, b, gap, sok, dok);
    checks++; if (gap !== 1)    begin errors++; $display("FAIL single_latency: got %0d want 1", gap); end
    checks++; if (b !== 8'hA5)  begin errors++; $display("FAIL single_data: got %h want a5", b); end
    checks++; if (sok !== 1'b1) begin errors++; $display("FAIL single_shape: got %b want 1", sok); end
    checks++; if (dok !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", dok); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || empty !== 1'b1 || tx !== 1'b1)
      begin errors++; $display("FAIL single_idle: busy=%b empty=%b tx=%b want 0 1 1", busy, empty, tx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b; int gap; bit sok, dok;
    wr_en = 1'b1; wr_data = 8'h00;
    @(negedge clk);
    wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    rx_frame(1, b, gap, sok, dok);
    checks++; if (b !== 8'h00 || sok !== 1'b1 || dok !== 1'b1)
      begin errors++; $display("FAIL b2b_first: data=%h shape=%b done=%b want 00 1 1", b, sok, dok); end
    rx_frame(0, b, gap, sok, dok);
    checks++; if (gap !== 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", gap); end
    checks++; if (b !== 8'hFF || sok !== 1'b1 || dok !== 1'b1)
      begin errors++; $display("FAIL b2b_second: data=%h shape=%b done=%b want ff 1 1", b, sok, dok); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || empty !== 1'b1)
      begin errors++; $display("FAIL b2b_idle: busy=%b empty=%b want 0 1", busy, empty); end
  endtask

  // Covers fill/overflow and the push dropped at the STOP->START edge while full.
  task automatic test_fill_overflow();
    logic [7:0] b; int gap; bit sok, dok, quiet;
    for (int i = 1; i <= 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      @(negedge clk);
      if (i == 8) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_not_full_8: got %b want 0", full); end
      end
      if (i == 9) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_9: got %b want 1", full); end
      end
    end
    wr_en = 1'b0;
    rx_frame(9, b, gap, sok, dok);
    checks++; if (b !== 8'h01 || sok !== 1'b1 || dok !== 1'b1)
      begin errors++; $display("FAIL fill_frame1: data=%h shape=%b done=%b want 01 1 1", b, sok, dok); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL pp_full_before: got %b want 1", full); end
    wr_en = 1'b1; wr_data = 8'hBB;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (full !== 1'b0 || empty !== 1'b0 || tx !== 1'b0)
      begin errors++; $display("FAIL pp_after_pop: full=%b empty=%b tx=%b want 0 0 0", full, empty, tx); end
    rx_frame(1, b, gap, sok, dok);
    checks++; if (b !== 8'h02 || sok !== 1'b1 || dok !== 1'b1)
      begin errors++; $display("FAIL fill_frame2: data=%h shape=%b done=%b want 02 1 1", b, sok, dok); end
    for (int v = 3; v <= 8; v++) begin
      rx_frame(0, b, gap, sok, dok);
      checks++; if (b !== 8'(v) || gap !== 1 || sok !== 1'b1 || dok !== 1'b1)
        begin errors++; $display("FAIL fill_frame%0d: data=%h gap=%0d shape=%b done=%b want %h 1 1 1", v, b, gap, sok, dok, 8'(v)); end
    end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty_before_last: got %b want 0", empty); end
    @(negedge clk);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty_after_last: got %b want 1", empty); end
    rx_frame(1, b, gap, sok, dok);
    checks++; if (b !== 8'h09 || sok !== 1'b1 || dok !== 1'b1)
      begin errors++; $display("FAIL fill_frame9: data=%h shape=%b done=%b want 09 1 1", b, sok, dok); end
    quiet = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL fill_dropped_bytes_sent: got %b want 1", quiet); end
  endtask

  task automatic test_reset_mid_frame();
    bit quiet;
    wr_en = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    wr_data = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (68) @(negedge clk);
    checks++; if (busy !== 1'b1 || empty !== 1'b0)
      begin errors++; $display("FAIL midrst_pre: busy=%b empty=%b want 1 0", busy, empty); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0)
      begin errors++; $display("FAIL midrst_async: tx=%b busy=%b empty=%b full=%b want 1 0 1 0", tx, busy, empty, full); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL midrst_quiet: got %b want 1", quiet); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
